// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared types and helpers for the multi-channel clock divider.
package clkdiv_pkg;
  localparam int DEF_DIV_W = 8;
  typedef logic [DEF_DIV_W-1:0] div_t;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int unsigned ceil_half(input int unsigned p);
    return (p + 1) / 2;
  endfunction
endpackage

// File: rtl/clkdiv_if.sv
// clkdiv_if: run enables, config write port and divided outputs of clkdiv_multi.
// Carries the align input only when CLKDIV_PHASE_ALIGN_EN is defined.
interface clkdiv_if #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 8
);
  import clkdiv_pkg::*;
  localparam int CH_W = ch_w(NUM_CH);
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] clk_out;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
`ifdef CLKDIV_PHASE_ALIGN_EN
  logic              align;
  modport master (output en, cfg_valid, cfg_ch, cfg_div, align, input cfg_ready, tick, clk_out);
  modport slave  (input en, cfg_valid, cfg_ch, cfg_div, align, output cfg_ready, tick, clk_out);
`else
  modport master (output en, cfg_valid, cfg_ch, cfg_div, input cfg_ready, tick, clk_out);
  modport slave  (input en, cfg_valid, cfg_ch, cfg_div, output cfg_ready, tick, clk_out);
`endif
endinterface

// File: rtl/clkdiv_chan.sv
// clkdiv_chan: one divider channel with active/shadow divide value and registered tick/square outputs.
module clkdiv_chan #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en_i,
  input  logic             align_i,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             pend_o,
  output logic             tick_o,
  output logic             clk_out_o
);
  import clkdiv_pkg::*;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, shadow_q, shadow_d;
  logic pend_q, pend_d, run_q, tick_q, tick_d, clk_q, clk_d, wrap, apply;
  function automatic logic [DIV_W-1:0] period(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction
  // a new divide value only lands where a fresh period starts anyway
  always_comb begin
    wrap     = run_q && (cnt_q == period(div_q) - DIV_W'(1));
    apply    = pend_q && (wrap || !run_q || !en_i);
    div_d    = apply ? shadow_q : div_q;
    pend_d   = wr_i || (pend_q && !apply);
    shadow_d = wr_i ? div_i : shadow_q;
    cnt_d    = (!en_i || !run_q || align_i || wrap) ? '0 : cnt_q + DIV_W'(1);
    tick_d   = en_i && (cnt_d == period(div_d) - DIV_W'(1));
    clk_d    = en_i && (cnt_d < DIV_W'(ceil_half(32'(period(div_d)))));
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q    <= '0;
      div_q    <= DIV_W'(DEFAULT_DIV);
      shadow_q <= DIV_W'(DEFAULT_DIV);
      pend_q   <= 1'b0;
      run_q    <= 1'b0;
      tick_q   <= 1'b0;
      clk_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      run_q    <= en_i;
      tick_q   <= tick_d;
      clk_q    <= clk_d;
    end
  end
  assign pend_o    = pend_q;
  assign tick_o    = tick_q;
  assign clk_out_o = clk_q;
endmodule

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: NUM_CH programmable tick/square-wave dividers with a valid/ready config port.
// Define CLKDIV_PHASE_ALIGN_EN to add the align input that restarts all enabled channels together.
module clkdiv_multi #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input logic     clk,
  input logic     clr,
  clkdiv_if.slave bus
);
  import clkdiv_pkg::*;
  localparam int CH_W = ch_w(NUM_CH);
  localparam int CH_N = 1 << CH_W;
  logic [NUM_CH-1:0] pend, wr, tick, clk_o;
  logic [CH_N-1:0]   pend_x;
  logic              align;
  // out-of-range channels read as never pending, so their writes are accepted and dropped
  always_comb begin
    pend_x               = '0;
    pend_x[NUM_CH-1:0]   = pend;
  end
  assign bus.cfg_ready = !clr && !pend_x[bus.cfg_ch];
`ifdef CLKDIV_PHASE_ALIGN_EN
  assign align = bus.align;
`else
  assign align = 1'b0;
`endif
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr[g] = bus.cfg_valid && bus.cfg_ready && (bus.cfg_ch == CH_W'(g));
    clkdiv_chan #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) u_chan (
      .clk      (clk),
      .clr      (clr),
      .en_i     (bus.en[g]),
      .align_i  (align),
      .wr_i     (wr[g]),
      .div_i    (bus.cfg_div),
      .pend_o   (pend[g]),
      .tick_o   (tick[g]),
      .clk_out_o(clk_o[g])
    );
  end
  assign bus.tick    = tick;
  assign bus.clk_out = clk_o;
endmodule

// File: tb/tb_clkdiv_multi.sv
// tb_clkdiv_multi: vector table, corner sequences and random traffic against a period-level model.
module tb_clkdiv_multi;
  import clkdiv_pkg::*;
  localparam int N  = 2;
  localparam int DW = 8;
  localparam int CW = ch_w(N);
  typedef struct {
    bit         c;
    logic [1:0] e;
    bit         v;
    int         ch;
    int         d;
    bit         rdy;
    logic [1:0] tk;
    logic [1:0] ck;
  } vec_t;
  logic clk = 1'b0;
  logic clr = 1'b1;
  logic clr3 = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int m_phase[N], m_per[N], m_shadow[N];
  bit m_pend[N], m_on[N];
  always #5 clk = ~clk;
  clkdiv_if #(.NUM_CH(N), .DIV_W(DW)) bus ();
  clkdiv_if #(.NUM_CH(3), .DIV_W(DW)) bus3 ();
  clkdiv_multi #(.NUM_CH(N), .DIV_W(DW), .DEFAULT_DIV(2)) dut (.clk(clk), .clr(clr), .bus(bus));
  clkdiv_multi #(.NUM_CH(3), .DIV_W(DW), .DEFAULT_DIV(2)) dut3 (.clk(clk), .clr(clr3), .bus(bus3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: each channel is a position within its current period of length per
  function automatic bit m_ready(input int ch);
    return (ch >= N) || !m_pend[ch];
  endfunction
  function automatic logic [N-1:0] m_tick();
    logic [N-1:0] t;
    for (int i = 0; i < N; i++) t[i] = m_on[i] && (m_phase[i] == m_per[i] - 1);
    return t;
  endfunction
  function automatic logic [N-1:0] m_clk();
    logic [N-1:0] t;
    for (int i = 0; i < N; i++) t[i] = m_on[i] && (m_phase[i] < (m_per[i] + 1) / 2);
    return t;
  endfunction
  task automatic m_edge(input bit c, input logic [N-1:0] e, input bit wr, input int ch, input int d, input bit a);
    for (int i = 0; i < N; i++) begin
      bit last;
      if (c) begin
        m_phase[i] = 0; m_per[i] = 2; m_pend[i] = 0; m_on[i] = 0;
      end else begin
        last = m_on[i] && (m_phase[i] == m_per[i] - 1);
        if (m_pend[i] && (last || !m_on[i] || !e[i])) begin
          m_per[i]  = (m_shadow[i] > 0) ? m_shadow[i] : 1;
          m_pend[i] = 0;
        end
        if (wr && ch == i) begin
          m_shadow[i] = d; m_pend[i] = 1;
        end
        if (!e[i]) begin
          m_on[i] = 0; m_phase[i] = 0;
        end else if (!m_on[i] || a || last) begin
          m_on[i] = 1; m_phase[i] = 0;
        end else m_phase[i]++;
      end
    end
  endtask

  task automatic step(input bit c, input logic [N-1:0] e, input bit v, input int ch, input int d,
                      input bit a, output logic rdy);
    bit wr, al;
    al = a;
`ifndef CLKDIV_PHASE_ALIGN_EN
    al = 1'b0;
`endif
    clr = c; bus.en = e; bus.cfg_valid = v; bus.cfg_ch = CW'(ch); bus.cfg_div = DW'(d);
`ifdef CLKDIV_PHASE_ALIGN_EN
    bus.align = al;
`endif
    #1;
    rdy = bus.cfg_ready;
    wr = v && !c && m_ready(ch);
    if (!c) chk("cfg_ready", 32'(rdy), 32'(m_ready(ch)));
    @(posedge clk);
    m_edge(c, e, wr, ch, d, al);
    #1;
    chk("tick", 32'(bus.tick), 32'(m_tick()));
    chk("clk_out", 32'(bus.clk_out), 32'(m_clk()));
  endtask

  task automatic idle(input int n);
    logic r;
    for (int k = 0; k < n; k++) step(0, 2'b11, 0, 0, 0, 0, r);
  endtask

  task automatic wr_wait(input int ch, input int d);
    logic r;
    step(0, 2'b11, 1, ch, d, 0, r);
    for (int k = 0; k < 600 && m_pend[ch]; k++) step(0, 2'b11, 0, ch, 0, 0, r);
  endtask

  initial begin
    vec_t tbl[13];
    logic r;
    int stalled, acc;
    int tt[$];
    logic [1:0] e;
    bus.en = '0; bus.cfg_valid = 0; bus.cfg_ch = '0; bus.cfg_div = '0;
    bus3.en = 3'b111; bus3.cfg_valid = 0; bus3.cfg_ch = '0; bus3.cfg_div = '0;
`ifdef CLKDIV_PHASE_ALIGN_EN
    bus.align = 0; bus3.align = 0;
`endif
    // out-of-range channel on a 3-channel instance: accepted, nothing changes
    @(posedge clk); #1; clr3 = 0;
    for (int k = 0; k < 8; k++) begin
      bus3.cfg_valid = (k == 2); bus3.cfg_ch = 2'd3; bus3.cfg_div = 8'd5;
      #1;
      if (k == 2) chk("oor_ready", 32'(bus3.cfg_ready), 32'd1);
      @(posedge clk); #1;
      chk("oor_clk", 32'(bus3.clk_out), (k % 2 == 0) ? 32'd7 : 32'd0);
      chk("oor_tick", 32'(bus3.tick), (k % 2 == 1) ? 32'd7 : 32'd0);
    end
    bus3.cfg_valid = 0;
    for (int ch = 0; ch < 3; ch++) begin
      bus3.cfg_ch = 2'(ch); #1;
      chk("oor_no_pend", 32'(bus3.cfg_ready), 32'd1);
    end
    clr3 = 1;
    // reset, default /2 on ch0 only, then reprogram ch0 to /5 mid-period
    tbl[0]  = '{1, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00};
    tbl[1]  = '{0, 2'b01, 0, 0, 0, 1, 2'b00, 2'b01};
    tbl[2]  = '{0, 2'b01, 0, 0, 0, 1, 2'b01, 2'b00};
    tbl[3]  = '{0, 2'b01, 0, 0, 0, 1, 2'b00, 2'b01};
    tbl[4]  = '{0, 2'b01, 0, 0, 0, 1, 2'b01, 2'b00};
    tbl[5]  = '{0, 2'b01, 0, 0, 0, 1, 2'b00, 2'b01};
    tbl[6]  = '{0, 2'b01, 1, 0, 5, 1, 2'b01, 2'b00};
    tbl[7]  = '{0, 2'b01, 0, 0, 0, 0, 2'b00, 2'b01};
    tbl[8]  = '{0, 2'b01, 0, 0, 0, 1, 2'b00, 2'b01};
    tbl[9]  = '{0, 2'b01, 0, 0, 0, 1, 2'b00, 2'b01};
    tbl[10] = '{0, 2'b01, 0, 0, 0, 1, 2'b00, 2'b00};
    tbl[11] = '{0, 2'b01, 0, 0, 0, 1, 2'b01, 2'b00};
    tbl[12] = '{0, 2'b01, 0, 0, 0, 1, 2'b00, 2'b01};
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].c, tbl[i].e, tbl[i].v, tbl[i].ch, tbl[i].d, 0, r);
      if (!tbl[i].c) chk($sformatf("tbl%0d_ready", i), 32'(r), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_tick", i), 32'(bus.tick), 32'(tbl[i].tk));
      chk($sformatf("tbl%0d_clk", i), 32'(bus.clk_out), 32'(tbl[i].ck));
    end
    // second write to a pending channel must stall until its boundary
    idle(4);
    step(0, 2'b11, 1, 1, 3, 0, r);
    stalled = 0; acc = 0;
    for (int k = 0; k < 12; k++) begin
      if (m_ready(1)) begin
        step(0, 2'b11, 1, 1, 3, 0, r);
        acc = 1;
        break;
      end
      step(0, 2'b11, 1, 1, 3, 0, r);
      if (r === 1'b0) stalled++;
    end
    chk("stall_seen", 32'(stalled > 0), 32'd1);
    chk("stall_accepted", 32'(acc), 32'd1);
    idle(8);
    // D=0 and D=1: tick every cycle, clk_out stuck high
    wr_wait(0, 0);
    for (int k = 0; k < 5; k++) begin
      idle(1);
      chk("d0_tick", 32'(bus.tick[0]), 32'd1);
      chk("d0_clk", 32'(bus.clk_out[0]), 32'd1);
    end
    wr_wait(0, 1);
    for (int k = 0; k < 5; k++) begin
      idle(1);
      chk("d1_tick", 32'(bus.tick[0]), 32'd1);
      chk("d1_clk", 32'(bus.clk_out[0]), 32'd1);
    end
    wr_wait(0, 255);
    for (int k = 0; k < 600 && tt.size() < 2; k++) begin
      idle(1);
      if (bus.tick[0] === 1'b1) tt.push_back(k);
    end
    chk("d255_ticks", 32'(tt.size()), 32'd2);
    if (tt.size() == 2) chk("d255_period", 32'(tt[1] - tt[0]), 32'd255);
    // clear mid-period with a write pending: back to /2, pending dropped
    wr_wait(0, 5);
    idle(1);
    step(0, 2'b11, 1, 0, 7, 0, r);
    step(1, 2'b11, 0, 0, 0, 0, r);
    chk("clr_tick", 32'(bus.tick), 32'd0);
    chk("clr_clk", 32'(bus.clk_out), 32'd0);
    step(0, 2'b11, 0, 0, 0, 0, r);
    chk("post_clr_ready", 32'(r), 32'd1);
    chk("post_clr_clk0", 32'(bus.clk_out), 32'd3);
    chk("post_clr_tick0", 32'(bus.tick), 32'd0);
    idle(1);
    chk("post_clr_clk1", 32'(bus.clk_out), 32'd0);
    chk("post_clr_tick1", 32'(bus.tick), 32'd3);
`ifdef CLKDIV_PHASE_ALIGN_EN
    wr_wait(0, 4);
    wr_wait(1, 6);
    idle(7);
    step(0, 2'b11, 0, 0, 0, 1, r);
    chk("align_clk", 32'(bus.clk_out), 32'd3);
    chk("align_tick", 32'(bus.tick), 32'd0);
    tt.delete();
    for (int k = 0; k < 24; k++) begin
      idle(1);
      if (bus.tick === 2'b11) tt.push_back(k);
    end
    chk("align_coincide_n", 32'(tt.size()), 32'd2);
    if (tt.size() > 0) chk("align_coincide_first", 32'(tt[0]), 32'd10);
`endif
    // random traffic against the model
    e = 2'b11;
    for (int k = 0; k < 1500; k++) begin
      int d;
      if ($urandom_range(0, 19) == 0) e = 2'($urandom);
      d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 7));
      step($urandom_range(0, 149) == 0, e, $urandom_range(0, 3) == 0, int'($urandom_range(0, N - 1)), d,
           $urandom_range(0, 39) == 0, r);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
